// File: rtl/ebrick_umi_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : ebrick_umi_mem_if
// Brief    : UMI device request/response channel bundle for ebrick_umi_mem.
//            master = requester side (EBRICK core host port),
//            slave  = memory device side.
// Revision : 1.0 - initial release
// ============================================================================
interface ebrick_umi_mem_if #(
  parameter int DW = 32,
  parameter int AW = 64,
  parameter int CW = 32
);

  // Request channel
  logic          udev_req_valid;
  logic [CW-1:0] udev_req_cmd;
  logic [AW-1:0] udev_req_dstaddr;
  logic [AW-1:0] udev_req_srcaddr;
  logic [DW-1:0] udev_req_data;
  logic          udev_req_ready;

  // Response channel
  logic          udev_resp_valid;
  logic [CW-1:0] udev_resp_cmd;
  logic [AW-1:0] udev_resp_dstaddr;
  logic [AW-1:0] udev_resp_srcaddr;
  logic [DW-1:0] udev_resp_data;
  logic          udev_resp_ready;

  modport master (
    output udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr,
           udev_req_data, udev_resp_ready,
    input  udev_req_ready, udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr,
           udev_resp_srcaddr, udev_resp_data
  );

  modport slave (
    input  udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr,
           udev_req_data, udev_resp_ready,
    output udev_req_ready, udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr,
           udev_resp_srcaddr, udev_resp_data
  );

endinterface
`default_nettype wire

// File: rtl/ebrick_umi_mem.sv
`default_nettype none
// ============================================================================
// Module   : ebrick_umi_mem
// Brief    : Single-port UMI device memory. Serves single-word read, write
//            and posted-write requests from the EBRICK core host port and
//            returns UMI responses through a one-entry response register.
//            Unsupported requests are consumed, dropped and counted.
// Revision : 1.0 - initial release
// ============================================================================
module ebrick_umi_mem #(
  parameter int DW    = 32,
  parameter int AW    = 64,
  parameter int CW    = 32,
  parameter int DEPTH = 1024
) (
  input  wire logic          clk,
  input  wire logic          reset,
  ebrick_umi_mem_if.slave    udev,
  output logic               err,
  output logic [15:0]        err_count
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [4:0] c_REQ_READ   = 5'h01;
  localparam logic [4:0] c_REQ_WRITE  = 5'h03;
  localparam logic [4:0] c_REQ_POSTED = 5'h05;
  localparam logic [4:0] c_RESP_READ  = 5'h02;
  localparam logic [4:0] c_RESP_WRITE = 5'h04;
  localparam logic [2:0] c_SIZE_WORD  = 3'd2;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t        state_q, state_d;

  logic [CW-1:0] resp_cmd_q, resp_cmd_d;
  logic [AW-1:0] resp_dst_q, resp_dst_d;
  logic [AW-1:0] resp_src_q, resp_src_d;
  logic          is_read_q,  is_read_d;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic [15:0]   err_count_q;

  logic [DW-1:0] mem_q [DEPTH];

  // Request decode
  logic [4:0]    w_opcode;
  logic [2:0]    w_size;
  logic [7:0]    w_len;
  logic          w_is_read, w_is_write, w_is_posted;
  logic          w_supported;
  logic          w_accept;
  logic          w_resp_acc;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_drop;
  logic [IW-1:0] w_idx;
  logic          w_unused;

  assign w_opcode    = udev.udev_req_cmd[4:0];
  assign w_size      = udev.udev_req_cmd[7:5];
  assign w_len       = udev.udev_req_cmd[15:8];
  assign w_is_read   = (w_opcode == c_REQ_READ);
  assign w_is_write  = (w_opcode == c_REQ_WRITE);
  assign w_is_posted = (w_opcode == c_REQ_POSTED);
  assign w_supported = (w_is_read | w_is_write | w_is_posted) &&
                       (w_size == c_SIZE_WORD) && (w_len == 8'd0) &&
                       (udev.udev_req_dstaddr[1:0] == 2'b00);

  // Upper address bits alias onto the array; upper command bits are ignored.
  assign w_idx    = udev.udev_req_dstaddr[IW+1:2];
  assign w_unused = ^udev.udev_req_cmd[CW-1:16];

  // Ready depends only on the response register state and resp_ready.
  assign udev.udev_req_ready = (state_q == S_EMPTY) | udev.udev_resp_ready;

  assign w_accept   = udev.udev_req_valid & udev.udev_req_ready;
  assign w_resp_acc = w_accept & w_supported & (w_is_read | w_is_write);
  // Writes during reset are suppressed so a reset cycle leaves memory intact.
  assign w_wr_en    = w_accept & w_supported & (w_is_write | w_is_posted) & ~reset;
  assign w_rd_en    = w_accept & w_supported & w_is_read;
  assign w_drop     = w_accept & ~w_supported;

  // Response register state
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // Next state: a new response-producing accept always wins over a drain
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (w_resp_acc) state_d = S_FULL;
      S_FULL: begin
        if (w_resp_acc)                state_d = S_FULL;
        else if (udev.udev_resp_ready) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Response field next values: loaded on a response-producing accept, else held
  always_comb begin
    resp_cmd_d = resp_cmd_q;
    resp_dst_d = resp_dst_q;
    resp_src_d = resp_src_q;
    is_read_d  = is_read_q;
    if (w_resp_acc) begin
      resp_cmd_d      = '0;
      resp_cmd_d[4:0] = w_is_read ? c_RESP_READ : c_RESP_WRITE;
      resp_cmd_d[7:5] = c_SIZE_WORD;
      resp_dst_d      = udev.udev_req_srcaddr;
      resp_src_d      = udev.udev_req_dstaddr;
      is_read_d       = w_is_read;
    end
  end

  // Response field registers
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_cmd_q <= '0;
      resp_dst_q <= '0;
      resp_src_q <= '0;
      is_read_q  <= 1'b0;
    end else begin
      resp_cmd_q <= resp_cmd_d;
      resp_dst_q <= resp_dst_d;
      resp_src_q <= resp_src_d;
      is_read_q  <= is_read_d;
    end
  end

  // Storage array with synchronous read port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[w_idx] <= udev.udev_req_data;
    if (w_rd_en) rdata_q      <= mem_q[w_idx];
  end

  // Sticky error flag and saturating drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q       <= 1'b0;
      err_count_q <= 16'd0;
    end else if (w_drop) begin
      err_q <= 1'b1;
      if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
    end
  end

  assign udev.udev_resp_valid   = (state_q == S_FULL);
  assign udev.udev_resp_cmd     = resp_cmd_q;
  assign udev.udev_resp_dstaddr = resp_dst_q;
  assign udev.udev_resp_srcaddr = resp_src_q;
  // Write responses carry zero data; rdata_q is only meaningful after a read.
  assign udev.udev_resp_data    = is_read_q ? rdata_q : '0;

  assign err       = err_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ebrick_umi_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_ebrick_umi_mem
// Brief    : Self-checking bench for ebrick_umi_mem. Expected responses are
//            queued when a request is accepted and compared as the device
//            hands them off.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ebrick_umi_mem;

  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [31:0] cmd;
    logic [63:0] dst;
    logic [63:0] src;
    logic [31:0] data;
  } rsp_t;

  logic        clk;
  logic        reset;
  logic        err;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  rsp_t        exp_q[$];
  int          pop_cyc[$];
  logic [31:0] model[int];
  rsp_t        mon_e;

  ebrick_umi_mem_if #(.DW(32), .AW(64), .CW(32)) u_if ();

  ebrick_umi_mem #(.DW(32), .AW(64), .CW(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .udev      (u_if.slave),
    .err       (err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] sz,
                                     input logic [7:0] ln);
    return {16'h0, ln, sz, op};
  endfunction

  // Bench model of the device: update memory and predict the response.
  function automatic void accept_model(input logic [31:0] cmd, input logic [63:0] dst,
                                       input logic [63:0] src, input logic [31:0] data);
    logic [4:0] op;
    logic       ok;
    int         idx;
    rsp_t       r;
    op  = cmd[4:0];
    idx = int'((dst >> 2) % DEPTH);
    ok  = (op == 5'h01 || op == 5'h03 || op == 5'h05) && cmd[7:5] == 3'd2 &&
          cmd[15:8] == 8'd0 && dst[1:0] == 2'b00;
    if (!ok) return;
    if (op == 5'h03 || op == 5'h05) model[idx] = data;
    if (op == 5'h01) begin
      r.cmd = 32'h42; r.dst = src; r.src = dst;
      r.data = model.exists(idx) ? model[idx] : 32'hxxxxxxxx;
      exp_q.push_back(r);
    end else if (op == 5'h03) begin
      r.cmd = 32'h44; r.dst = src; r.src = dst; r.data = 32'h0;
      exp_q.push_back(r);
    end
  endfunction

  // Advance to the sampling edge; retire any response handed off this cycle.
  task automatic sample_edge();
    @(negedge clk);
    cyc++;
    if (!reset && u_if.udev_resp_valid && u_if.udev_resp_ready) begin
      pop_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp got cmd=%h src=%h want none",
                 u_if.udev_resp_cmd, u_if.udev_resp_srcaddr);
      end else begin
        mon_e = exp_q.pop_front();
        if ({u_if.udev_resp_cmd, u_if.udev_resp_dstaddr, u_if.udev_resp_srcaddr,
             u_if.udev_resp_data} !== mon_e) begin
          errors++;
          $display("FAIL resp got cmd=%h dst=%h src=%h data=%h want cmd=%h dst=%h src=%h data=%h",
                   u_if.udev_resp_cmd, u_if.udev_resp_dstaddr, u_if.udev_resp_srcaddr,
                   u_if.udev_resp_data, mon_e.cmd, mon_e.dst, mon_e.src, mon_e.data);
        end
      end
    end
  endtask

  task automatic send(input logic [31:0] cmd, input logic [63:0] dst, input logic [63:0] src,
                      input logic [31:0] data, output int waits);
    logic rdy;
    u_if.udev_req_valid   = 1'b1;
    u_if.udev_req_cmd     = cmd;
    u_if.udev_req_dstaddr = dst;
    u_if.udev_req_srcaddr = src;
    u_if.udev_req_data    = data;
    waits = 0;
    forever begin
      sample_edge();
      rdy = u_if.udev_req_ready;
      if (rdy) accept_model(cmd, dst, src, data);
      @(posedge clk); #1;
      if (rdy) break;
      waits++;
      if (waits > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout got no accept want accept dst=%h", dst);
        break;
      end
    end
    u_if.udev_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      sample_edge();
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    sample_edge();
    checks++;
    if ({u_if.udev_req_ready, u_if.udev_resp_valid, err, err_count} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b err=%b cnt=%h want 1 0 0 0000",
               u_if.udev_req_ready, u_if.udev_resp_valid, err, err_count);
    end
    checks++;
    if ({u_if.udev_resp_cmd, u_if.udev_resp_dstaddr, u_if.udev_resp_srcaddr, u_if.udev_resp_data} !== '0) begin
      errors++;
      $display("FAIL reset_fields got cmd=%h dst=%h src=%h data=%h want 0",
               u_if.udev_resp_cmd, u_if.udev_resp_dstaddr, u_if.udev_resp_srcaddr, u_if.udev_resp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_posted_read();
    int w;
    send(mk(5'h05, 3'd2, 8'd0), 64'h10, 64'h0, 32'hDEADBEEF, w);
    sample_edge();
    checks++;
    if (u_if.udev_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL posted_noresp got vld=%b want 0", u_if.udev_resp_valid);
    end
    @(posedge clk); #1;
    send(mk(5'h01, 3'd2, 8'd0), 64'h10, 64'h2000, 32'h0, w);
    sample_edge();
    checks++;
    if (u_if.udev_resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_latency got vld=%b want 1", u_if.udev_resp_valid);
    end
    checks++;
    if (u_if.udev_resp_cmd !== 32'h42 || u_if.udev_resp_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_first got cmd=%h data=%h want 00000042 deadbeef",
               u_if.udev_resp_cmd, u_if.udev_resp_data);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_write_alias();
    int w;
    send(mk(5'h03, 3'd2, 8'd0), 64'h4, 64'h3000, 32'h12345678, w);
    send(mk(5'h01, 3'd2, 8'd0), 64'h4 + 64'(4 * DEPTH), 64'h3004, 32'h0, w);
    drain();
  endtask

  task automatic test_back_to_back();
    int w, total;
    for (int i = 0; i < 8; i++)
      send(mk(5'h05, 3'd2, 8'd0), 64'h100 + 64'(4 * i), 64'h0, 32'hA0000000 + 32'(i * 32'h111), w);
    pop_cyc.delete();
    total = 0;
    for (int i = 0; i < 8; i++) begin
      send(mk(5'h01, 3'd2, 8'd0), 64'h100 + 64'(4 * i), 64'h5000 + 64'(i), 32'h0, w);
      total += w;
    end
    drain();
    checks++;
    if (total != 0) begin
      errors++;
      $display("FAIL stream_ready got %0d stall cycles want 0", total);
    end
    checks++;
    if (pop_cyc.size() != 8) begin
      errors++;
      $display("FAIL stream_count got %0d responses want 8", pop_cyc.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (pop_cyc[i] != pop_cyc[i-1] + 1) begin
          errors++;
          $display("FAIL stream_gap got gap %0d at %0d want 1", pop_cyc[i] - pop_cyc[i-1], i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    u_if.udev_resp_ready = 1'b0;
    send(mk(5'h01, 3'd2, 8'd0), 64'h100, 64'h7000, 32'h0, w);
    u_if.udev_req_valid   = 1'b1;
    u_if.udev_req_cmd     = mk(5'h01, 3'd2, 8'd0);
    u_if.udev_req_dstaddr = 64'h104;
    u_if.udev_req_srcaddr = 64'h7001;
    u_if.udev_req_data    = 32'h0;
    for (int k = 0; k < 3; k++) begin
      sample_edge();
      checks++;
      if (u_if.udev_req_ready !== 1'b0 || u_if.udev_resp_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_ready got rdy=%b vld=%b want 0 1", u_if.udev_req_ready, u_if.udev_resp_valid);
      end
      checks++;
      if ({u_if.udev_resp_cmd, u_if.udev_resp_dstaddr, u_if.udev_resp_srcaddr, u_if.udev_resp_data} !==
          {32'h42, 64'h7000, 64'h100, 32'hA0000000}) begin
        errors++;
        $display("FAIL bp_stable got cmd=%h dst=%h src=%h data=%h want 42 7000 100 a0000000",
                 u_if.udev_resp_cmd, u_if.udev_resp_dstaddr, u_if.udev_resp_srcaddr, u_if.udev_resp_data);
      end
      @(posedge clk); #1;
    end
    u_if.udev_resp_ready = 1'b1;
    sample_edge();
    checks++;
    if (u_if.udev_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got rdy=%b want 1", u_if.udev_req_ready);
    end else accept_model(u_if.udev_req_cmd, 64'h104, 64'h7001, 32'h0);
    @(posedge clk); #1;
    u_if.udev_req_valid = 1'b0;
    drain();
  endtask

  task automatic test_unsupported();
    int w;
    send(mk(5'h05, 3'd2, 8'd0), 64'h0, 64'h0, 32'hCAFEF00D, w);
    sample_edge();
    checks++;
    if (err !== 1'b0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL err_pre got err=%b cnt=%h want 0 0000", err, err_count);
    end
    @(posedge clk); #1;
    send(mk(5'h01, 3'd0, 8'd0), 64'h10, 64'h8000, 32'h0, w);
    send(mk(5'h03, 3'd2, 8'd1), 64'h10, 64'h8001, 32'h11111111, w);
    send(mk(5'h07, 3'd2, 8'd0), 64'h10, 64'h8002, 32'h0, w);
    send(mk(5'h03, 3'd2, 8'd0), 64'h2, 64'h8003, 32'h22222222, w);
    sample_edge();
    checks++;
    if (err !== 1'b1 || err_count !== 16'd4) begin
      errors++;
      $display("FAIL err_post got err=%b cnt=%h want 1 0004", err, err_count);
    end
    checks++;
    if (u_if.udev_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_noresp got vld=%b want 0", u_if.udev_resp_valid);
    end
    @(posedge clk); #1;
    send(mk(5'h01, 3'd2, 8'd0), 64'h0, 64'h8100, 32'h0, w);
    send(mk(5'h01, 3'd2, 8'd0), 64'h10, 64'h8101, 32'h0, w);
    drain();
  endtask

  task automatic test_reset_mid();
    int w;
    u_if.udev_resp_ready = 1'b0;
    send(mk(5'h01, 3'd2, 8'd0), 64'h10, 64'h6000, 32'h0, w);
    sample_edge();
    checks++;
    if (u_if.udev_resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pending got vld=%b want 1", u_if.udev_resp_valid);
    end
    @(posedge clk); #1;
    reset                 = 1'b1;
    u_if.udev_resp_ready  = 1'b1;
    u_if.udev_req_valid   = 1'b1;
    u_if.udev_req_cmd     = mk(5'h05, 3'd2, 8'd0);
    u_if.udev_req_dstaddr = 64'h10;
    u_if.udev_req_srcaddr = 64'h0;
    u_if.udev_req_data    = 32'h0BAD0BAD;
    @(posedge clk); #1;
    reset               = 1'b0;
    u_if.udev_req_valid = 1'b0;
    exp_q.delete();
    sample_edge();
    checks++;
    if ({u_if.udev_resp_valid, u_if.udev_req_ready, err, err_count, u_if.udev_resp_cmd} !==
        {1'b0, 1'b1, 1'b0, 16'h0, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid got vld=%b rdy=%b err=%b cnt=%h cmd=%h want 0 1 0 0000 0",
               u_if.udev_resp_valid, u_if.udev_req_ready, err, err_count, u_if.udev_resp_cmd);
    end
    @(posedge clk); #1;
    send(mk(5'h01, 3'd2, 8'd0), 64'h10, 64'h6001, 32'h0, w);
    drain();
  endtask

  initial begin
    reset                 = 1'b1;
    u_if.udev_req_valid   = 1'b0;
    u_if.udev_req_cmd     = '0;
    u_if.udev_req_dstaddr = '0;
    u_if.udev_req_srcaddr = '0;
    u_if.udev_req_data    = '0;
    u_if.udev_resp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_posted_read();
    test_write_alias();
    test_back_to_back();
    test_backpressure();
    test_unsupported();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ebrick_umi_mem.md
# ebrick_umi_mem

Single-port UMI device memory that sits directly downstream of the EBRICK core's UMI host port (core request/response channels). It accepts single-word read, write and posted-write requests and returns UMI responses, so a simulation can run core firmware memory traffic without a software monitor. Unsupported requests are consumed, dropped and counted.

## Interface
- DW, 32: data width; must be 32.
- AW, 64: address width.
- CW, 32: command width.
- DEPTH, 1024: number of 32-bit words; power of two, ≥2.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- udev_req_valid  in  1  request valid.
- udev_req_cmd  in  CW  request command.
- udev_req_dstaddr  in  AW  request target address.
- udev_req_srcaddr  in  AW  requester return address.
- udev_req_data  in  DW  write data.
- udev_req_ready  out  1  request accepted when high with valid.
- udev_resp_valid  out  1  response valid.
- udev_resp_cmd  out  CW  response command.
- udev_resp_dstaddr  out  AW  response destination (= request srcaddr).
- udev_resp_srcaddr  out  AW  response source (= request dstaddr).
- udev_resp_data  out  DW  read data; 0 for write responses.
- udev_resp_ready  in  1  downstream accepts response.
- err  out  1  sticky: set on any dropped request.
- err_count  out  16  saturating count of dropped requests.

## Operation
- cmd fields: opcode = cmd[4:0], size = cmd[7:5], len = cmd[15:8].
- Supported: REQ_READ 0x01, REQ_WRITE 0x03, REQ_POSTED 0x05, only with size=2, len=0, dstaddr[1:0]=0.
- Word index = dstaddr[log2(DEPTH)+1:2]; higher address bits ignored (aliasing, wrap at DEPTH).
- Accept = req_valid & req_ready.
- REQ_WRITE/REQ_POSTED: write req_data to array at accept edge. REQ_WRITE also produces response opcode RESP_WRITE 0x04, data 0.
- REQ_READ: synchronous array read at accept edge; response opcode RESP_READ 0x02, data = word.
- Response cmd: [4:0]=response opcode, [7:5]=2, [15:8]=0, all other bits 0. dstaddr/srcaddr swapped from request.
- Unsupported (any other opcode, size≠2, len≠0, misaligned): accepted like any request, no array access, no response; err set, err_count +1 saturating at 0xFFFF.
- Response register: one entry, states EMPTY / FULL. EMPTY→FULL on accept of a response-producing request; FULL→EMPTY on resp_ready with no new response-producing accept; FULL stays FULL (contents replaced) when resp_ready and a response-producing accept coincide.
- req_ready = !resp_valid | resp_ready (combinational from resp_ready only; no path from req_valid).
- Array contents not cleared by reset; undefined until written.

## Timing
- Reset: req_ready=1, resp_valid=0, resp_cmd/dstaddr/srcaddr/data=0, err=0, err_count=0.
- Reset mid-operation: pending response discarded; array writes in the reset cycle are not performed.
- Latency: request accepted at edge N → resp_valid high after edge N (visible cycle N+1).
- Throughput: one request per cycle while resp_ready held high.
- Response fields stable while resp_valid=1 and resp_ready=0.
- Read of a word written in an earlier accepted cycle returns new data (no hazard); posted write then read back-to-back returns written data.
- Posted and unsupported requests never stall on a full response register only if it drains: they still obey req_ready.

## Test plan
- After reset, REQ_POSTED to 0x10 data 0xDEADBEEF, then REQ_READ 0x10 srcaddr 0x2000 -> one response: cmd 0x00000042, dstaddr 0x2000, srcaddr 0x10, data 0xDEADBEEF, one cycle after read accept.
- REQ_WRITE addr 0x4 data 0x12345678 srcaddr 0x3000 -> response cmd 0x00000044, data 0, dstaddr 0x3000; then read 0x4 + 4*DEPTH -> 0x12345678 (aliasing).
- Stream 8 back-to-back reads with resp_ready=1 -> 8 responses on consecutive cycles, req_ready never low.
- Hold resp_ready=0 with two reads pending -> req_ready=0 after first accept, response fields stable; release -> second accepted in same cycle, order preserved.
- Send size=0 read, len=1 write, opcode 0x07, addr 0x2 -> no responses, err=1, err_count=4, memory unchanged.
- Assert reset while resp_valid=1 -> next cycle resp_valid=0, err_count=0, req_ready=1.
